// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES constants and types for the key schedule and cipher datapath.
//   NUM_ROUNDS  : number of AES-128 rounds (round keys 1..NUM_ROUNDS follow key 0)
//   RCON        : round constants Rcon[1..10], stored at index 0..9
//   ke_state_e  : key-expansion FSM state
//   rcon()      : Rcon lookup by round number, 0 outside 1..NUM_ROUNDS
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  // RCON[i] holds Rcon[i+1].
  localparam logic [7:0] RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ke_state_e;

  // Round numbers outside 1..NUM_ROUNDS return 0 so callers can evaluate
  // the lookup unconditionally (e.g. past the last round) without harm.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] val;
    val = 8'h00;
    if (round >= 4'd1 && round <= 4'(NUM_ROUNDS)) begin
      val = RCON[round - 4'd1];
    end
    return val;
  endfunction

endpackage

// File: rtl/key_expansion_if.sv
// -----------------------------------------------------------------------------
// key_expansion_if
// Bundles the key-expansion request and the round-key memory write port.
//   start, key          : expansion request (requester -> expander)
//   busy, done          : expansion status (expander -> requester)
//   mem_we, mem_addr,
//   mem_din             : round-key write port (expander -> memory)
// Modports:
//   master : the key expander (drives status and the write port)
//   slave  : the requester / round-key memory side
//
// Handshake: there is no ready. start is a request level that the expander
// samples only while idle, latching key on that same edge; once accepted,
// busy (== mem_we) stays high for the whole write burst and done pulses for
// one cycle afterwards. mem_we is a write strobe the memory must accept on
// every cycle it is high; mem_addr/mem_din are only meaningful with mem_we.
// -----------------------------------------------------------------------------
interface key_expansion_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [DATA_WIDTH-1:0] key;
  logic                  busy;
  logic                  done;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  modport master (
    input  start, key,
    output busy, done, mem_we, mem_addr, mem_din
  );

  modport slave (
    output start, key,
    input  busy, done, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box, shared by the key schedule and the cipher.
//   sbox_in  : 8-bit input byte
//   sbox_out : 8-bit substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  // Byte for input 8'h00 sits in the top bits, 8'hff in the bottom bits.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // (255 - sbox_in) * 8 is the LSB of the selected byte.
  logic [10:0] bit_idx;

  always_comb begin
    bit_idx  = {~sbox_in, 3'b000};
    sbox_out = SBOX_TABLE[bit_idx +: 8];
  end

endmodule

// File: rtl/key_expansion.sv
// -----------------------------------------------------------------------------
// key_expansion
// AES-128 key schedule. On an accepted start it writes round keys 0..10 into
// an external round-key memory on consecutive cycles, then pulses done.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   start     : expansion request, sampled only in IDLE
//   key       : cipher key ([127:96] = w0), sampled with start
//   busy      : high during the write burst (equals mem_we)
//   done      : one-cycle pulse after the last round key is written
//   mem_we    : round-key memory write enable
//   mem_addr  : round index being written
//   mem_din   : round key being written
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module key_expansion
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_KEYS   = 11,
  parameter int ADDR_WIDTH = $clog2(NUM_KEYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] key,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_KEYS - 1);

  ke_state_e             state_q,     state_d;
  logic                  mem_we_q,    mem_we_d;
  logic                  done_q,      done_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  // Working key register: holds the latched cipher key, then each round key
  // in turn. It doubles as the mem_din register, so mem_din always shows the
  // round key the next one is derived from.
  logic [DATA_WIDTH-1:0] round_key_q, round_key_d;

  logic [31:0]           w0, w1, w2, w3;
  logic [31:0]           rot_w3, sub_w3, t_word;
  logic [31:0]           n0, n1, n2, n3;
  logic [DATA_WIDTH-1:0] next_key;

  // ---------------------------------------------------------------------------
  // Next round key from the current one (addr_q = r produces round r+1).
  // ---------------------------------------------------------------------------
  assign {w0, w1, w2, w3} = round_key_q;
  assign rot_w3           = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (
      .sbox_in  (rot_w3[8*i +: 8]),
      .sbox_out (sub_w3[8*i +: 8])
    );
  end

  // rcon() returns 0 past the last round, so the unused value computed while
  // sitting on the last address is harmless.
  assign t_word   = sub_w3 ^ {rcon(4'(addr_q) + 4'd1), 24'h000000};
  assign n0       = w0 ^ t_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // ---------------------------------------------------------------------------
  // FSM next-state and output-register logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
    addr_d      = addr_q;
    round_key_d = round_key_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          round_key_d = key;
          addr_d      = '0;
          mem_we_d    = 1'b1;
          state_d     = ST_EXPAND;
        end
      end

      ST_EXPAND: begin
        if (addr_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          round_key_d = next_key;
          addr_d      = addr_q + 1'b1;
          mem_we_d    = 1'b1;
        end
      end

      // One cycle for the done pulse; start is ignored here so a held start
      // is only re-sampled on the following IDLE edge.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      round_key_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      round_key_q <= round_key_d;
    end
  end

  assign busy     = mem_we_q;
  assign mem_we   = mem_we_q;
  assign done     = done_q;
  assign mem_addr = addr_q;
  assign mem_din  = round_key_q;

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SHALL set the key and round-key width in bits.
REQ-002 Parameter NUM_KEYS, default 11, SHALL set the number of round keys produced (round 0 to round 10).
REQ-003 Parameter ADDR_WIDTH, default $clog2(NUM_KEYS), SHALL set the round-key address width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port start, input, 1 bit: request to expand key; sampled only in IDLE.
REQ-007 Port key, input, DATA_WIDTH bits: AES-128 cipher key, bits [127:96] = w0; sampled on the same edge as start.
REQ-008 Port busy, output, 1 bit: high while round keys are being written.
REQ-009 Port done, output, 1 bit: one-cycle pulse after the last round key is written.
REQ-010 Port mem_we, output, 1 bit: write enable to the round-key memory.
REQ-011 Port mem_addr, output, ADDR_WIDTH bits: round index being written.
REQ-012 Port mem_din, output, DATA_WIDTH bits: round key being written.

Function
REQ-013 The block SHALL implement the FSM states IDLE, EXPAND and DONE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL register key; on the same edge it SHALL set mem_we=1, mem_addr=0, mem_din=key and go to EXPAND.
REQ-015 In EXPAND, each edge SHALL compute round key r+1 from the registered round key r, raise mem_addr by 1 and keep mem_we=1.
REQ-016 Round key r+1 SHALL be formed as follows:
- t = SubWord(RotWord(w3)) XOR {Rcon[r+1], 24'h0}
- w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
REQ-017 Rcon[1..10] SHALL be 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
REQ-018 mem_we SHALL be high for exactly NUM_KEYS consecutive cycles, with addresses 0 to 10 in ascending order and no gaps.
REQ-019 With start sampled at edge T, the write cycles SHALL be T+1 to T+11 and done SHALL be high in cycle T+12 only; after that the FSM SHALL return to IDLE.
REQ-020 busy SHALL equal mem_we; done and busy SHALL never both be high.
REQ-021 start SHALL be ignored while in EXPAND or DONE; a start present during the done cycle SHALL be ignored.
REQ-022 start held high continuously SHALL begin a new expansion on the first IDLE edge after done, re-sampling key at that edge.
REQ-023 Outside write cycles, mem_we SHALL be 0 and mem_addr/mem_din SHALL hold their last values.
REQ-024 All outputs SHALL be driven directly from registers, with no combinational path from start or key.

Reset
REQ-025 rst=1 SHALL immediately force:
- state = IDLE
- busy = done = mem_we = 0
- mem_addr = 0, mem_din = 0, key register = 0
REQ-026 Reset during EXPAND SHALL abort the expansion with no further writes and no done pulse; after release the block SHALL accept start normally.

Structure
REQ-027 The constants NUM_ROUNDS=10 and the RCON table SHALL be declared in the shared package aes_pkg.
REQ-028 The FSM state enum SHALL also be declared in aes_pkg.
REQ-029 SubWord SHALL use four instances of the combinational sub-module aes_sbox (8-bit in, 8-bit out); aes_sbox SHALL be reused by the cipher datapath.

Verification
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c -> addr 0 = key, addr 1 = a0fafe1788542cb123a339392a6c7605, addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done at T+12.
REQ-031 Key all-zero -> addr 1 = 62636363626363636263636362636363, addr 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-032 start pulsed at cycles T+3 and T+12 during an expansion -> both ignored, exactly 11 writes, a single done pulse.
REQ-033 rst asserted at cycle T+5 -> mem_we=0 at once, no done pulse; a new start then gives a correct full sequence.
REQ-034 start held high across two expansions -> two back-to-back sequences separated by the done cycle and one IDLE cycle, each using the key sampled at its own start.
REQ-035 Bench connects the block to the round-key memory -> each of addresses 0 to 10 read back matches the expected round key.
